// File: rtl/ultra_pkg.sv
// Shared types and helpers for the ultra_pack symbol packer.
//   sym_t      : 9-bit symbol, [7:0] data, [8] flag
//   word_t     : 36-bit FIFO write word, four lanes
//   LANES      : symbols per word
//   lane_place : insert a symbol into one lane of a word
package ultra_pkg;

    typedef logic [8:0]  sym_t;
    typedef logic [35:0] word_t;

    localparam int LANES = 4;

    // Lane k keeps its data byte in [8k+7:8k] and its flag in bit 32+k, which
    // is the order the 36-to-9 FIFO reads symbols back out.
    function automatic word_t lane_place(input word_t w, input logic [1:0] lane, input sym_t s);
        word_t r;
        r = w;
        r[8*int'(lane) +: 8] = s[7:0];
        r[32 + int'(lane)]   = s[8];
        return r;
    endfunction

endpackage

// File: rtl/ultra_pack.sv
// ultra_pack: packs 9-bit symbols four to a 36-bit word for the 36-in/9-out
// output FIFO, with partial-word flush, almost-full back-pressure and a
// running count of written words.
//
// Ports:
//   CLK        in   clock, also the FIFO write clock
//   RST        in   asynchronous active-high reset
//   SYM        in   9  symbol (data [7:0], flag [8])
//   SYM_VALID  in   symbol presented
//   SYM_READY  out  symbol accepted this cycle when valid
//   FLUSH      in   single-cycle request to emit a partial word
//   FULL       in   FIFO almost-full
//   DI         out  36  FIFO write data
//   WREN       out  FIFO write enable
//   WORDS      out  CNT_W  words written, wrapping
//   BUSY       out  partial word held or flush pending
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FILL      | accumulating symbols into lanes
// FLUSHWAIT | flush requested, waiting for an edge with FULL low
module ultra_pack
    import ultra_pkg::*;
#(
    parameter sym_t PAD   = 9'h000,
    parameter int   CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [8:0]       SYM,
    input  logic             SYM_VALID,
    output logic             SYM_READY,
    input  logic             FLUSH,
    input  logic             FULL,
    output logic [35:0]      DI,
    output logic             WREN,
    output logic [CNT_W-1:0] WORDS,
    output logic             BUSY
);

    typedef enum logic {
        FILL      = 1'b0,
        FLUSHWAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       lane_q, lane_d;
    word_t            word_q, word_d;
    word_t            di_q, di_d;
    logic             wren_q, wren_d;
    logic [CNT_W-1:0] words_q, words_d;
    // Keeps SYM_READY low through reset until the first edge after release.
    logic             rdy_en_q;

    logic  accept;
    word_t placed;
    word_t padded;

    assign SYM_READY = rdy_en_q && !FULL && (state_q == FILL);
    assign accept    = SYM_VALID && SYM_READY;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        di_d    = di_q;
        wren_d  = 1'b0;
        words_d = words_q;
        placed  = lane_place(word_q, lane_q, SYM);
        padded  = word_q;
        for (int k = 0; k < LANES; k++) begin
            if (k >= int'(lane_q)) begin
                padded = lane_place(padded, 2'(k), PAD);
            end
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (lane_q == 2'd3) begin
                        di_d   = placed;
                        wren_d = 1'b1;
                        word_d = '0;
                        lane_d = 2'd0;
                    end else begin
                        word_d = placed;
                        lane_d = lane_q + 2'd1;
                    end
                end
                // A symbol taken on the same edge lands first; the pending
                // flush then acts on whatever word that leaves behind.
                if (FLUSH) begin
                    state_d = FLUSHWAIT;
                end
            end
            FLUSHWAIT: begin
                if (!FULL) begin
                    state_d = FILL;
                    if (lane_q != 2'd0) begin
                        di_d   = padded;
                        wren_d = 1'b1;
                        word_d = '0;
                        lane_d = 2'd0;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (wren_d) begin
            words_d = words_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= FILL;
            lane_q   <= 2'd0;
            word_q   <= '0;
            di_q     <= '0;
            wren_q   <= 1'b0;
            words_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            word_q   <= word_d;
            di_q     <= di_d;
            wren_q   <= wren_d;
            words_q  <= words_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign DI    = di_q;
    assign WREN  = wren_q;
    assign WORDS = words_q;
    assign BUSY  = (lane_q != 2'd0) || (state_q == FLUSHWAIT);

endmodule

// File: doc/ultra_pack.md
Name: ultra_pack

Overview:
- Upstream feeder for the 36-in/9-out output FIFO.
- Accepts a stream of 9-bit symbols (8 data bits plus a flag bit) and packs four symbols per 36-bit FIFO write word.
- Lane order matches the FIFO's 36-to-9 read order, so the FIFO reads the symbols back out in arrival order.
- Supports flushing a partial word with pad symbols, back-pressure from the FIFO's almost-full, and a running word count.

Parameters:
- PAD, 9'h000, symbol written into unused lanes on flush.
- CNT_W, 16, width of the written-word counter.

Ports:
- CLK  input  1  single clock; also the FIFO write clock.
- RST  input  1  asynchronous, active-high reset.
- SYM  input  9  symbol; SYM[7:0] is data, SYM[8] is the flag.
- SYM_VALID  input  1  SYM is presented this cycle.
- SYM_READY  output  1  block accepts SYM this cycle.
- FLUSH  input  1  single-cycle request to emit any partial word.
- FULL  input  1  FIFO almost-full; writes must stop.
- DI  output  36  FIFO write data.
- WREN  output  1  FIFO write enable.
- WORDS  output  CNT_W  count of words written; wraps.
- BUSY  output  1  a partial word is held, or a flush is pending.

Behaviour:
- Reset is asynchronous on RST rising, active-high; all state is cleared at once.
  - Outputs under reset: DI=0, WREN=0, WORDS=0, BUSY=0, SYM_READY=0.
  - On the first CLK edge after release, SYM_READY follows the rules below.
- Lane mapping: symbol in lane k (k=0..3, first-arrived is lane 0) occupies DI[8k+7:8k] and DI[32+k].
- Accept rule: a symbol is accepted on a CLK edge with SYM_VALID && SYM_READY.
  - SYM_READY = !FULL && !flush_pending.
  - The block is combinational in FULL only; SYM_READY does not depend on SYM_VALID.
- Lane counter: 2 bits, 0..3. Each accepted symbol is written into the current lane and the counter increments.
- Full word: accepting the symbol into lane 3 registers the complete word.
  - WREN=1 and DI=word on the next cycle, for exactly one cycle.
  - The lane counter wraps to 0.
  - Latency from the 4th symbol accept to WREN is 1 cycle.
  - Back-to-back full words give WREN every 4 accepted symbols; no bubbles are added.
- DI hold: DI holds its last value while WREN=0. The verifier checks DI only while WREN=1.
- FLUSH request: sets flush_pending, which persists until serviced. A FLUSH while flush_pending is already set is absorbed.
- Flush service: occurs on the first edge with flush_pending && !FULL.
  - If lane counter > 0: lanes from the counter to 3 are filled with PAD, WREN pulses next cycle, WORDS increments, and the counter goes to 0.
  - If lane counter = 0: no write.
  - Either way, flush_pending clears.
- FLUSH together with an accepted symbol in the same cycle: the symbol is accepted first, then the flush applies to the word containing it.
  - If that symbol completed the word, only the normal write occurs. No extra all-PAD word is ever produced.
- FULL handling:
  - No new WREN is issued on a cycle following an edge where FULL was sampled high.
  - A WREN already registered from the previous edge still completes; the FIFO's almost-full margin absorbs it.
  - A completed word produced while FULL is asserted cannot occur, because acceptance is gated by FULL.
- WORDS increments by 1 in the same cycle WREN=1 and wraps modulo 2^CNT_W.
- BUSY = (lane counter != 0) || flush_pending.
- Reset mid-word: the partial word is discarded. No WREN occurs during or after reset until new symbols arrive.
- State machine:
  - FILL: normal accumulation.
  - FLUSHWAIT: flush_pending and FULL; SYM_READY=0.
  - Return from FLUSHWAIT to FILL on the flush service edge.
  - The lane counter is held orthogonal to these states.

Decomposition:
- Shared package ultra_pkg holds:
  - typedef sym_t as a 9-bit symbol;
  - typedef word_t as 36 bits;
  - constant LANES=4;
  - function lane_place(word_t, lane, sym_t), which returns the word with the symbol inserted using the lane mapping above.
- No sub-module is required. The block is a single module.
- The bench instantiates ultra_pack directly into fifo_out, with matching CLK and WRCLK, for end-to-end checks.

Test Plan:
- Full word: SYM 9'h001, 9'h102, 9'h003, 9'h104 on consecutive cycles, FULL=0 -> one cycle after the 4th accept, WREN=1, DI=36'hA_04030201, WORDS=1.
- Partial flush: SYM 9'h0AA, 9'h1BB, then FLUSH, PAD=0 -> WREN=1, DI=36'h2_0000BBAA, BUSY goes 1 then 0.
- Flush on completing symbol: 4th symbol 9'h0DD accepted with FLUSH high in the same cycle -> exactly one WREN, no pad word, WORDS advances by 1.
- Back-pressure: FULL=1 held for 10 cycles while SYM_VALID=1 -> SYM_READY=0 and no WREN; after FULL=0, the stream resumes with no lost or duplicated symbols (checked through fifo_out read-back).
- Flush while full: 1 symbol held, FLUSH with FULL=1 -> no WREN and SYM_READY=0; FULL drops -> next cycle WREN with 3 PAD lanes.
- Reset mid-word: 2 symbols accepted, RST pulsed asynchronously between edges -> WREN=0, WORDS=0, BUSY=0 immediately; the next 4 symbols form a clean word.
